// File: rtl/tcdm_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_bank_arbiter_if
// Brief    : Requester-side and bank-side signal bundle of the TCDM bank arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface tcdm_bank_arbiter_if #(
    parameter int unsigned NumIn     = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned BeWidth = DataWidth / 8;

    // requester side
    logic [NumIn-1:0]                req_valid_i;
    logic [NumIn-1:0]                req_ready_o;
    logic [NumIn-1:0][AddrWidth-1:0] req_addr_i;
    logic [NumIn-1:0][3:0]           req_amo_i;
    logic [NumIn-1:0]                req_write_i;
    logic [NumIn-1:0][DataWidth-1:0] req_wdata_i;
    logic [NumIn-1:0][BeWidth-1:0]   req_be_i;
    logic [NumIn-1:0]                resp_valid_o;
    logic [NumIn-1:0]                resp_ready_i;
    logic [DataWidth-1:0]            resp_rdata_o;

    // bank (adapter) side
    logic                            bank_valid_o;
    logic                            bank_ready_i;
    logic [AddrWidth-1:0]            bank_addr_o;
    logic [3:0]                      bank_amo_o;
    logic                            bank_write_o;
    logic [DataWidth-1:0]            bank_wdata_o;
    logic [BeWidth-1:0]              bank_be_o;
    logic                            bank_rvalid_i;
    logic                            bank_rready_o;
    logic [DataWidth-1:0]            bank_rdata_i;

    // arbiter view
    modport slave (
        input  req_valid_i, req_addr_i, req_amo_i, req_write_i, req_wdata_i, req_be_i,
        input  resp_ready_i, bank_ready_i, bank_rvalid_i, bank_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o,
        output bank_valid_o, bank_addr_o, bank_amo_o, bank_write_o, bank_wdata_o, bank_be_o,
        output bank_rready_o
    );

    // environment view (requesters plus adapter)
    modport master (
        output req_valid_i, req_addr_i, req_amo_i, req_write_i, req_wdata_i, req_be_i,
        output resp_ready_i, bank_ready_i, bank_rvalid_i, bank_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o,
        input  bank_valid_o, bank_addr_o, bank_amo_o, bank_write_o, bank_wdata_o, bank_be_o,
        input  bank_rready_o
    );
endinterface
`default_nettype wire

// File: rtl/tcdm_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_bank_arbiter
// Brief    : Round-robin sharing of one TCDM bank between NumIn requesters, with
//            an in-order ID FIFO routing responses back. Optional conflict
//            counter enabled by macro TCDM_BANK_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tcdm_bank_arbiter #(
    parameter int unsigned NumIn       = 4,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned IdFifoDepth = 2
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    tcdm_bank_arbiter_if.slave     bus,
    output logic [31:0]            perf_conflicts_o
);
    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned IdW     = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int unsigned PtrW    = (IdFifoDepth > 1) ? $clog2(IdFifoDepth) : 1;
    localparam int unsigned CntW    = $clog2(IdFifoDepth + 1);
    localparam logic [CntW-1:0] C_DEPTH   = CntW'(IdFifoDepth);
    localparam logic [PtrW-1:0] C_PTR_MAX = PtrW'(IdFifoDepth - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IdW-1:0]  rr_q;
    logic            lock_q;
    logic [IdW-1:0]  lock_idx_q;
    logic [IdW-1:0]  r_id_mem [IdFifoDepth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [IdW-1:0]       w_rr_winner;
    logic                 w_rr_found;
    logic [IdW-1:0]       w_winner;
    logic                 w_any_valid;
    logic                 w_resp_prod;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_blocked;
    logic                 w_bank_valid;
    logic                 w_handshake;
    logic                 w_push;
    logic                 w_pop;
    logic [IdW-1:0]       w_head;
    logic                 w_rready;
    logic [AddrWidth-1:0] w_bank_addr;
    logic [DataWidth-1:0] w_bank_wdata;
    logic [BeWidth-1:0]   w_bank_be;

    function automatic logic [IdW-1:0] f_wrap(input logic [IdW-1:0] base, input int unsigned ofs);
        int unsigned sum;
        sum = 32'(base) + ofs;
        if (sum >= NumIn) sum = sum - NumIn;
        return sum[IdW-1:0];
    endfunction

    function automatic logic [PtrW-1:0] f_ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == C_PTR_MAX) ? '0 : ptr + PtrW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Arbitration: first valid requester at or after rr_q, wrapping
    // ------------------------------------------------------------------
    always_comb begin : p_rr_search
        w_rr_winner = rr_q;
        w_rr_found  = 1'b0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            if (!w_rr_found && bus.req_valid_i[f_wrap(rr_q, k)]) begin
                w_rr_winner = f_wrap(rr_q, k);
                w_rr_found  = 1'b1;
            end
        end
    end

    // A stalled grant stays with its requester until the bank accepts it
    assign w_winner     = lock_q ? lock_idx_q : w_rr_winner;
    assign w_any_valid  = |bus.req_valid_i;
    assign w_resp_prod  = !bus.req_write_i[w_winner] || (bus.req_amo_i[w_winner] != 4'd0);

    assign w_full       = (r_count == C_DEPTH);
    assign w_empty      = (r_count == '0);
    // Full is taken from the registered count, so a same-cycle pop never unblocks
    assign w_blocked    = w_full && w_resp_prod;
    assign w_bank_valid = w_any_valid && !w_blocked;
    assign w_handshake  = w_bank_valid && bus.bank_ready_i;
    assign w_push       = w_handshake && w_resp_prod;

    always_comb begin : p_req_ready
        bus.req_ready_o           = '0;
        bus.req_ready_o[w_winner] = w_handshake;
    end

    assign w_bank_addr      = bus.req_addr_i[w_winner];
    assign w_bank_wdata     = bus.req_wdata_i[w_winner];
    assign w_bank_be        = bus.req_be_i[w_winner];

    assign bus.bank_valid_o = w_bank_valid;
    assign bus.bank_addr_o  = w_bank_addr;
    assign bus.bank_amo_o   = bus.req_amo_i[w_winner];
    assign bus.bank_write_o = bus.req_write_i[w_winner];
    assign bus.bank_wdata_o = w_bank_wdata;
    assign bus.bank_be_o    = w_bank_be;

    always_ff @(posedge clk_i or negedge rst_ni) begin : p_arb_state
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (w_handshake) begin
            rr_q       <= f_wrap(w_winner, 1);
            lock_q     <= 1'b0;
        end else if (w_bank_valid) begin
            lock_q     <= 1'b1;
            lock_idx_q <= w_winner;
        end
    end

    // ------------------------------------------------------------------
    // Response routing through the in-order ID FIFO
    // ------------------------------------------------------------------
    assign w_head   = r_id_mem[r_rd_ptr];
    assign w_rready = !w_empty && bus.resp_ready_i[w_head];
    assign w_pop    = bus.bank_rvalid_i && w_rready;

    always_comb begin : p_resp_route
        bus.resp_valid_o         = '0;
        bus.resp_valid_o[w_head] = bus.bank_rvalid_i && !w_empty;
    end

    assign bus.bank_rready_o = w_rready;
    assign bus.resp_rdata_o  = bus.bank_rdata_i;

    // Storage needs no reset: validity is tracked by r_count alone
    always_ff @(posedge clk_i) begin : p_id_mem
        if (w_push) r_id_mem[r_wr_ptr] <= w_winner;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : p_fifo_ctrl
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Conflict counter
    // ------------------------------------------------------------------
`ifdef TCDM_BANK_ARB_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk_i or negedge rst_ni) begin : p_perf
        if (!rst_ni) begin
            r_perf <= '0;
        end else if (($countones(bus.req_valid_i) >= 2) && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_conflicts_o = r_perf;
`else
    assign perf_conflicts_o = 32'd0;
`endif

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    a_bank_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_bank_valid && !bus.bank_ready_i) |=>
            (w_bank_valid && $stable(w_bank_addr) && $stable(bus.bank_amo_o) &&
             $stable(bus.bank_write_o) && $stable(w_bank_wdata) && $stable(w_bank_be)));

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_push && w_full));

    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_pop && w_empty));

    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.bank_rvalid_i && w_empty));
`endif

endmodule
`default_nettype wire

// File: tb/tb_tcdm_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcdm_bank_arbiter
// Brief    : Vector table, directed corner sequences and randomized traffic
//            against a queue-based reference model of tcdm_bank_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcdm_bank_arbiter;
    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
`ifdef TCDM_BANK_ARB_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] perf;

    always #5 clk_i = ~clk_i;

    tcdm_bank_arbiter_if #(.NumIn(N), .AddrWidth(AW), .DataWidth(DW)) bus ();

    tcdm_bank_arbiter #(
        .NumIn(N), .AddrWidth(AW), .DataWidth(DW), .IdFifoDepth(DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .bus              (bus),
        .perf_conflicts_o (perf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid_i   = '0;
        bus.req_write_i   = '0;
        bus.req_amo_i     = '0;
        bus.req_addr_i    = '0;
        bus.req_wdata_i   = '0;
        bus.req_be_i      = '0;
        bus.resp_ready_i  = '0;
        bus.bank_ready_i  = 1'b0;
        bus.bank_rvalid_i = 1'b0;
        bus.bank_rdata_i  = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic wr);
        bus.req_valid_i[i] = v;
        bus.req_write_i[i] = wr;
        bus.req_amo_i[i]   = 4'd0;
        bus.req_addr_i[i]  = 32'h100 + 32'(i);
        bus.req_wdata_i[i] = 32'hD000 + 32'(i);
        bus.req_be_i[i]    = 4'hF;
    endtask

    // Apply one cycle of stimulus and move to the sampling point
    task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic br,
                         input logic rv, input logic [31:0] rd);
        for (int i = 0; i < N; i++) set_req(i, v[i], w[i]);
        bus.bank_ready_i  = br;
        bus.bank_rvalid_i = rv;
        bus.bank_rdata_i  = rd;
        @(negedge clk_i);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bank_valid"}, 64'(bus.bank_valid_o), 64'd0);
        chk({tag, "_req_ready"},  64'(bus.req_ready_o),  64'd0);
        chk({tag, "_resp_valid"}, 64'(bus.resp_valid_o), 64'd0);
        chk({tag, "_rready"},     64'(bus.bank_rready_o), 64'd0);
        chk({tag, "_rdata"},      64'(bus.resp_rdata_o), 64'd0);
        chk({tag, "_addr_wdata"}, {bus.bank_addr_o, bus.bank_wdata_o}, 64'd0);
        chk({tag, "_ctl"},        64'({bus.bank_write_o, bus.bank_amo_o, bus.bank_be_o}), 64'd0);
        chk({tag, "_perf"},       64'(perf), 64'd0);
    endtask

    // ---------------- reference model ----------------
    int m_rr, m_lock, m_lock_idx, m_perf;
    int m_q[$];

    task automatic model_reset();
        m_rr = 0; m_lock = 0; m_lock_idx = 0; m_perf = 0;
        m_q.delete();
    endtask

    function automatic int m_winner();
        if (m_lock != 0) return m_lock_idx;
        for (int k = 0; k < N; k++) begin
            int idx = (m_rr + k) % N;
            if (bus.req_valid_i[idx]) return idx;
        end
        return m_rr;
    endfunction

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        bus.resp_ready_i = '1;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] write;
        logic       bank_ready;
        logic       exp_bv;
        logic [3:0] exp_ready;
        int         exp_src;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // priority order, then stall/lock behaviour, all plain stores
        tbl[0]  = '{4'hF,    4'hF, 1'b1, 1'b1, 4'b0001, 0};
        tbl[1]  = '{4'hF,    4'hF, 1'b1, 1'b1, 4'b0010, 1};
        tbl[2]  = '{4'hF,    4'hF, 1'b1, 1'b1, 4'b0100, 2};
        tbl[3]  = '{4'hF,    4'hF, 1'b1, 1'b1, 4'b1000, 3};
        tbl[4]  = '{4'hF,    4'hF, 1'b1, 1'b1, 4'b0001, 0};
        tbl[5]  = '{4'b0100, 4'hF, 1'b1, 1'b1, 4'b0100, 2};
        tbl[6]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 4'b0000, -1};
        tbl[7]  = '{4'b0100, 4'hF, 1'b0, 1'b1, 4'b0000, 2};
        tbl[8]  = '{4'b0101, 4'hF, 1'b0, 1'b1, 4'b0000, 2};
        tbl[9]  = '{4'b0101, 4'hF, 1'b0, 1'b1, 4'b0000, 2};
        tbl[10] = '{4'b0101, 4'hF, 1'b1, 1'b1, 4'b0100, 2};
        tbl[11] = '{4'b0101, 4'hF, 1'b1, 1'b1, 4'b0001, 0};
        tbl[12] = '{4'b1010, 4'hF, 1'b0, 1'b1, 4'b0000, 1};
        tbl[13] = '{4'b1010, 4'hF, 1'b1, 1'b1, 4'b0010, 1};
        tbl[14] = '{4'b1010, 4'hF, 1'b1, 1'b1, 4'b1000, 3};

        // ---- reset state ----
        clear_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk_all_zero("reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        bus.resp_ready_i = '1;
        model_reset();

        // ---- table ----
        for (int t = 0; t < 15; t++) begin
            drive(tbl[t].valid, tbl[t].write, tbl[t].bank_ready, 1'b0, 32'd0);
            chk($sformatf("tbl%0d_bank_valid", t), 64'(bus.bank_valid_o), 64'(tbl[t].exp_bv));
            chk($sformatf("tbl%0d_req_ready", t),  64'(bus.req_ready_o),  64'(tbl[t].exp_ready));
            if (tbl[t].exp_src >= 0)
                chk($sformatf("tbl%0d_addr_wdata", t), {bus.bank_addr_o, bus.bank_wdata_o},
                    {32'h100 + 32'(tbl[t].exp_src), 32'hD000 + 32'(tbl[t].exp_src)});
            next_cycle();
        end

        // ---- loads from 1 and 3, in-order routing ----
        do_reset();
        drive(4'b0010, 4'b0000, 1'b1, 1'b0, 32'd0);
        chk("ld1_ready", 64'(bus.req_ready_o), 64'b0010);
        next_cycle();
        drive(4'b1000, 4'b0000, 1'b1, 1'b0, 32'd0);
        chk("ld3_ready", 64'(bus.req_ready_o), 64'b1000);
        next_cycle();
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'hAAAA);
        chk("rsp_a_valid", 64'(bus.resp_valid_o), 64'b0010);
        chk("rsp_a_data",  64'(bus.resp_rdata_o), 64'hAAAA);
        chk("rsp_a_rready", 64'(bus.bank_rready_o), 64'd1);
        next_cycle();
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'hBBBB);
        chk("rsp_b_valid", 64'(bus.resp_valid_o), 64'b1000);
        chk("rsp_b_data",  64'(bus.resp_rdata_o), 64'hBBBB);
        next_cycle();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'd0);
        chk("drained_rready", 64'(bus.bank_rready_o), 64'd0);
        next_cycle();

        // ---- store between two loads leaves only 1,1 in the FIFO ----
        drive(4'b0010, 4'b0000, 1'b1, 1'b0, 32'd0);
        chk("wf_ld1a", 64'(bus.req_ready_o), 64'b0010);
        next_cycle();
        drive(4'b0001, 4'b0001, 1'b1, 1'b0, 32'd0);
        chk("wf_st0", 64'(bus.req_ready_o), 64'b0001);
        next_cycle();
        drive(4'b0010, 4'b0000, 1'b1, 1'b0, 32'd0);
        chk("wf_ld1b", 64'(bus.req_ready_o), 64'b0010);
        next_cycle();
        bus.resp_ready_i = 4'b0001;
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h1234);
        chk("wf_head_is_1", 64'(bus.resp_valid_o), 64'b0010);
        chk("wf_head_backpressure", 64'(bus.bank_rready_o), 64'd0);
        next_cycle();
        bus.resp_ready_i = '1;
        for (int r = 0; r < 2; r++) begin
            drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h5555 + 32'(r));
            chk($sformatf("wf_rsp%0d_valid", r), 64'(bus.resp_valid_o), 64'b0010);
            next_cycle();
        end
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'd0);
        chk("wf_empty", 64'(bus.bank_rready_o), 64'd0);
        next_cycle();

        // ---- FIFO full blocks loads, not stores ----
        do_reset();
        drive(4'b0001, 4'b0000, 1'b1, 1'b0, 32'd0);
        chk("full_ld0", 64'(bus.req_ready_o), 64'b0001);
        next_cycle();
        drive(4'b0010, 4'b0000, 1'b1, 1'b0, 32'd0);
        chk("full_ld1", 64'(bus.req_ready_o), 64'b0010);
        next_cycle();
        drive(4'b0100, 4'b0000, 1'b1, 1'b0, 32'd0);
        chk("full_ld2_blocked", 64'(bus.bank_valid_o), 64'd0);
        chk("full_ld2_noready", 64'(bus.req_ready_o), 64'd0);
        next_cycle();
        drive(4'b1000, 4'b1000, 1'b1, 1'b0, 32'd0);
        chk("full_st3_granted", 64'(bus.req_ready_o), 64'b1000);
        next_cycle();
        drive(4'b0100, 4'b0000, 1'b1, 1'b1, 32'h1111);
        chk("full_pop_still_blocked", 64'(bus.bank_valid_o), 64'd0);
        chk("full_pop_resp", 64'(bus.resp_valid_o), 64'b0001);
        next_cycle();
        drive(4'b0100, 4'b0000, 1'b1, 1'b0, 32'd0);
        chk("full_ld2_after_pop", 64'(bus.req_ready_o), 64'b0100);
        next_cycle();

        // ---- reset with two IDs outstanding ----
        clear_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk_all_zero("midrst");
        bus.resp_ready_i  = '1;
        bus.bank_rvalid_i = 1'b1;
        #1;
        chk("midrst_no_resp", 64'(bus.resp_valid_o), 64'd0);
        chk("midrst_no_rready", 64'(bus.bank_rready_o), 64'd0);
        bus.bank_rvalid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        drive(4'b1000, 4'b0000, 1'b1, 1'b0, 32'd0);
        chk("post_rst_ld3", 64'(bus.req_ready_o), 64'b1000);
        next_cycle();
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'hCCCC);
        chk("post_rst_resp", 64'(bus.resp_valid_o), 64'b1000);
        chk("post_rst_data", 64'(bus.resp_rdata_o), 64'hCCCC);
        next_cycle();

        // ---- conflict counter ----
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(4'b0011, 4'b0011, 1'b1, 1'b0, 32'd0);
            next_cycle();
        end
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'd0);
        chk("perf_after_5", 64'(perf), PERF_EN ? 64'd5 : 64'd0);
        next_cycle();

        // ---- randomized traffic against the model ----
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int w, head;
            bit any, prod, ebv, egrant, err;
            for (int i = 0; i < N; i++) begin
                if (!(m_lock != 0 && i == m_lock_idx)) begin
                    bus.req_valid_i[i] = ($urandom_range(0, 99) < 45);
                    bus.req_write_i[i] = 1'($urandom_range(0, 1));
                    bus.req_amo_i[i]   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                    bus.req_addr_i[i]  = $urandom;
                    bus.req_wdata_i[i] = $urandom;
                    bus.req_be_i[i]    = 4'($urandom);
                end
            end
            bus.bank_ready_i  = ($urandom_range(0, 3) != 0);
            bus.resp_ready_i  = 4'($urandom) | 4'($urandom);
            bus.bank_rvalid_i = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.bank_rdata_i  = $urandom;

            any    = (bus.req_valid_i != '0);
            w      = m_winner();
            prod   = !bus.req_write_i[w] || (bus.req_amo_i[w] != 4'd0);
            ebv    = any && !(m_q.size() == DEPTH && prod);
            egrant = ebv && bus.bank_ready_i;
            head   = (m_q.size() > 0) ? m_q[0] : -1;
            err    = (head >= 0) && bus.resp_ready_i[head];

            @(negedge clk_i);
            chk("rnd_bank_valid", 64'(bus.bank_valid_o), 64'(ebv));
            chk("rnd_req_ready", 64'(bus.req_ready_o), egrant ? (64'd1 << w) : 64'd0);
            chk("rnd_resp_valid", 64'(bus.resp_valid_o),
                (head >= 0 && bus.bank_rvalid_i) ? (64'd1 << head) : 64'd0);
            chk("rnd_rready", 64'(bus.bank_rready_o), 64'(err));
            chk("rnd_rdata", 64'(bus.resp_rdata_o), 64'(bus.bank_rdata_i));
            chk("rnd_perf", 64'(perf), 64'(m_perf));
            if (any) begin
                chk("rnd_addr_wdata", {bus.bank_addr_o, bus.bank_wdata_o},
                    {bus.req_addr_i[w], bus.req_wdata_i[w]});
                chk("rnd_ctl", 64'({bus.bank_write_o, bus.bank_amo_o, bus.bank_be_o}),
                    64'({bus.req_write_i[w], bus.req_amo_i[w], bus.req_be_i[w]}));
            end

            if (PERF_EN && $countones(bus.req_valid_i) >= 2) m_perf++;
            if (egrant) begin
                m_rr   = (w + 1) % N;
                m_lock = 0;
                if (prod) m_q.push_back(w);
            end else if (ebv) begin
                m_lock     = 1;
                m_lock_idx = w;
            end
            if (bus.bank_rvalid_i && err) void'(m_q.pop_front());
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
